// File: rtl/btn_pkg.sv
// Shared defaults, repeat-FSM encoding and sizing helpers
// for the debounced button scanner.
package btn_pkg;

    localparam int N_BTN_DEF         = 4;
    localparam int TICK_DIV_DEF      = 100_000;
    localparam int STABLE_TICKS_DEF  = 20;
    localparam int HOLD_DELAY_DEF    = 300;
    localparam int REPEAT_PERIOD_DEF = 50;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // A counter for 0..n-1 needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: tick-based debounce, edge pulses
// and the hold / auto-repeat state machine.
module btn_chan
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS  = STABLE_TICKS_DEF,
    parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic sync_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int SW = cnt_width(STABLE_TICKS);
    localparam int RW = cnt_width(max_int(HOLD_DELAY, REPEAT_PERIOD));

    localparam logic [SW-1:0] S_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] H_LAST = RW'(HOLD_DELAY - 1);
    localparam logic [RW-1:0] P_LAST = RW'(REPEAT_PERIOD - 1);

    logic [SW-1:0] stab_q, stab_d;
    logic          level_q, level_d;
    logic          press_q, release_q;
    logic          rep_q, rep_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rep_state_e    state_q, state_d;
    logic          rise, fall;

    always_comb begin
        stab_d  = stab_q;
        level_d = level_q;
        if (sync_i == level_q) begin
            stab_d = '0;
        end else if (tick_i) begin
            if (stab_q == S_LAST) begin
                level_d = sync_i;
                stab_d  = '0;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // A falling level wins over any repeat tick in the same cycle.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_d   = 1'b0;
        if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = DELAY;
                        rcnt_d  = '0;
                    end
                end
                DELAY: begin
                    if (tick_i) begin
                        if (rcnt_q == H_LAST) begin
                            rep_d   = 1'b1;
                            state_d = REPEAT;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (tick_i) begin
                        if (rcnt_q == P_LAST) begin
                            rep_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stab_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rep_q     <= 1'b0;
            rcnt_q    <= '0;
            state_q   <= IDLE;
        end else begin
            stab_q    <= stab_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
            rep_q     <= rep_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = rep_q;

endmodule

// File: rtl/btn_scan_ctrl.sv
// Button scanner top: input synchronizers, shared sample-tick
// prescaler and one debounce/repeat channel per button.
module btn_scan_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN         = N_BTN_DEF,
    parameter int TICK_DIV      = TICK_DIV_DEF,
    parameter int STABLE_TICKS  = STABLE_TICKS_DEF,
    parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_chan #(
            .STABLE_TICKS  (STABLE_TICKS),
            .HOLD_DELAY    (HOLD_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .sync_i    (sync2_q[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g]),
            .repeat_o  (btn_repeat[g])
        );
    end

endmodule
